// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
// Optional burst mode is enabled by defining WRITE_ARB_BURST_EN.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam arb_state_e STATE_RST     = IDLE;
  localparam logic [7:0] BURST_CNT_RST = 8'd0;

  // Width of a producer index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Reset value of last_grant so that producer 0 wins the first arbitration.
  function automatic int last_grant_rst(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: scans the request vector starting at
// i_start, wrapping modulo NUM_REQ, and reports the first set bit.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_valid
);

  int               w_pos;
  logic [IDX_W-1:0] w_pos_idx;

  // Walk the requesters in rotated order and latch onto the first one found.
  always_comb begin
    o_onehot  = '0;
    o_index   = '0;
    o_valid   = 1'b0;
    w_pos     = 0;
    w_pos_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos     = (int'(i_start) + k) % NUM_REQ;
      w_pos_idx = IDX_W'(w_pos);
      if (!o_valid && i_req[w_pos_idx]) begin
        o_valid             = 1'b1;
        o_index             = w_pos_idx;
        o_onehot[w_pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Write-side arbiter sharing one FIFO write port among NUM_REQ producers.
// Round-robin per write; backs off while the FIFO is full.
// Define WRITE_ARB_BURST_EN to let a winner hold the port for up to
// MAX_BURST consecutive writes.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int IDX_W      = idx_width(NUM_REQ)
) (
  input  logic                          clk_write,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                          flag_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          req_write,
  output logic [DATA_WIDTH-1:0]         data_write,
  output logic                          busy
);

  localparam logic [IDX_W-1:0] LastGrantRst = IDX_W'(last_grant_rst(NUM_REQ));

  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   w_start;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_id;
  logic               w_pick_valid;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [IDX_W-1:0]   w_win_id;

  // Search begins just after the previous winner, wrapping to producer 0.
  always_comb begin
    w_start = (r_last_grant == LastGrantRst) ? '0 : r_last_grant + 1'b1;
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req    (req),
    .i_start  (w_start),
    .o_onehot (w_pick_onehot),
    .o_index  (w_pick_id),
    .o_valid  (w_pick_valid)
  );

`ifdef WRITE_ARB_BURST_EN
  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic [7:0]       r_burst_cnt;
  logic [7:0]       w_burst_cnt_next;
  logic [IDX_W-1:0] w_last_grant_next;
  logic             w_owner_req;

  assign w_owner_req = req[r_last_grant];

  // Next-state and grant selection; in BURST the owner is r_last_grant.
  always_comb begin
    w_state_next      = r_state;
    w_burst_cnt_next  = r_burst_cnt;
    w_last_grant_next = r_last_grant;
    w_win_onehot      = '0;
    w_win_id          = '0;
    if (!reset && !flag_full) begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            w_win_onehot      = w_pick_onehot;
            w_win_id          = w_pick_id;
            w_last_grant_next = w_pick_id;
            if (MAX_BURST > 1) begin
              w_state_next     = BURST;
              w_burst_cnt_next = 8'd1;
            end
          end
        end
        BURST: begin
          if (!w_owner_req) begin
            w_state_next     = IDLE;
            w_burst_cnt_next = BURST_CNT_RST;
          end else begin
            w_win_onehot = NUM_REQ'(1) << r_last_grant;
            w_win_id     = r_last_grant;
            if (r_burst_cnt + 8'd1 == 8'(MAX_BURST)) begin
              w_state_next     = IDLE;
              w_burst_cnt_next = BURST_CNT_RST;
            end else begin
              w_burst_cnt_next = r_burst_cnt + 8'd1;
            end
          end
        end
        default: begin
          w_state_next     = IDLE;
          w_burst_cnt_next = BURST_CNT_RST;
        end
      endcase
    end
  end

  // State, burst counter and rotation pointer registers.
  always_ff @(posedge clk_write or posedge reset) begin
    if (reset) begin
      r_state      <= STATE_RST;
      r_burst_cnt  <= BURST_CNT_RST;
      r_last_grant <= LastGrantRst;
    end else begin
      r_state      <= w_state_next;
      r_burst_cnt  <= w_burst_cnt_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  assign busy = (r_state == BURST);
`else
  // Plain round-robin: grant the picker's choice whenever a write is possible.
  always_comb begin
    w_win_onehot = '0;
    w_win_id     = '0;
    if (!reset && !flag_full && w_pick_valid) begin
      w_win_onehot = w_pick_onehot;
      w_win_id     = w_pick_id;
    end
  end

  // Rotation pointer advances only on an actual write.
  always_ff @(posedge clk_write or posedge reset) begin
    if (reset) begin
      r_last_grant <= LastGrantRst;
    end else if (|w_win_onehot) begin
      r_last_grant <= w_win_id;
    end
  end

  assign busy = 1'b0;
`endif

  // Drive the FIFO write port from the selected producer, zeros when idle.
  always_comb begin
    grant      = w_win_onehot;
    grant_id   = w_win_id;
    req_write  = |w_win_onehot;
    data_write = '0;
    if (|w_win_onehot) begin
      data_write = data_in[int'(w_win_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule
